// File: rtl/brg_cgra_pkg.sv
// rtl/brg_cgra_pkg.sv - shared request/response types and FSM states for the CGRA link arbiter
package brg_cgra_pkg;

  localparam int AddrWidth  = 28;
  localparam int DataWidth  = 32;
  localparam int RegIdWidth = 5;

  typedef struct packed {
    logic                 store;
    logic [AddrWidth-1:0] addr;
    logic [DataWidth-1:0] data;
  } brg_cgra_req_t;

  typedef struct packed {
    logic                  load;
    logic [RegIdWidth-1:0] reg_id;
    logic [DataWidth-1:0]  data;
  } brg_cgra_resp_t;

  typedef enum logic {
    IDLE,
    LOCKED
  } brg_cgra_state_e;

endpackage

// File: rtl/brg_cgra_req_credit_arbiter_if.sv
// rtl/brg_cgra_req_credit_arbiter_if.sv - request, forward-packet and return bundle of one link row
interface brg_cgra_req_credit_arbiter_if #(
  parameter int num_ports_p    = 4,
  parameter int addr_width_p   = 28,
  parameter int data_width_p   = 32,
  parameter int reg_id_width_p = 5
);

  logic [num_ports_p-1:0]              req_v;
  logic [num_ports_p-1:0]              req_store;
  logic [num_ports_p*addr_width_p-1:0] req_addr;
  logic [num_ports_p*data_width_p-1:0] req_data;
  logic [num_ports_p-1:0]              req_ready;

  logic                      pkt_v;
  logic                      pkt_store;
  logic [addr_width_p-1:0]   pkt_addr;
  logic [data_width_p-1:0]   pkt_data;
  logic [reg_id_width_p-1:0] pkt_reg_id;
  logic                      pkt_ready;

  logic                      ret_v;
  logic                      ret_load;
  logic [reg_id_width_p-1:0] ret_reg_id;
  logic [data_width_p-1:0]   ret_data;

  logic [num_ports_p-1:0]    resp_v;
  logic [data_width_p-1:0]   resp_data;

  modport master (
    output req_v, req_store, req_addr, req_data, pkt_ready,
    output ret_v, ret_load, ret_reg_id, ret_data,
    input  req_ready, pkt_v, pkt_store, pkt_addr, pkt_data, pkt_reg_id,
    input  resp_v, resp_data
  );

  modport slave (
    input  req_v, req_store, req_addr, req_data, pkt_ready,
    input  ret_v, ret_load, ret_reg_id, ret_data,
    output req_ready, pkt_v, pkt_store, pkt_addr, pkt_data, pkt_reg_id,
    output resp_v, resp_data
  );

endinterface

// File: rtl/brg_cgra_rr_picker.sv
// rtl/brg_cgra_rr_picker.sv - combinational round-robin picker searching from ptr_i+1 with wrap-around
module brg_cgra_rr_picker #(
  parameter  int num_ports_p = 4,
  localparam int IdxW        = $clog2(num_ports_p)
) (
  input  logic [num_ports_p-1:0] req_i,
  input  logic [IdxW-1:0]        ptr_i,
  output logic [num_ports_p-1:0] grant_o,
  output logic [IdxW-1:0]        idx_o,
  output logic                   v_o
);

  logic [IdxW-1:0] cand;

  // Walk from farthest to nearest so the last hit is the closest port after ptr_i.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    v_o     = 1'b0;
    cand    = '0;
    for (int i = num_ports_p; i >= 1; i--) begin
      cand = IdxW'((int'(ptr_i) + i) % num_ports_p);
      if (req_i[cand]) begin
        v_o   = 1'b1;
        idx_o = cand;
      end
    end
    if (v_o) grant_o[idx_o] = 1'b1;
  end

endmodule

// File: rtl/brg_cgra_req_credit_arbiter.sv
// rtl/brg_cgra_req_credit_arbiter.sv - credit-gated round-robin merge of CGRA requests onto one link, with response steering
module brg_cgra_req_credit_arbiter
  import brg_cgra_pkg::*;
#(
  parameter  int num_ports_p       = 4,
  parameter  int addr_width_p      = 28,
  parameter  int data_width_p      = 32,
  parameter  int max_out_credits_p = 32,
  parameter  int reg_id_width_p    = 5,
  localparam int CredW             = $clog2(max_out_credits_p + 1)
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  brg_cgra_req_credit_arbiter_if.slave bus,
  output logic [CredW-1:0]      out_credits_o,
  output logic                  idle_o,
  output logic                  err_o
);

  localparam int              IdxW    = $clog2(num_ports_p);
  localparam logic [CredW-1:0] MaxCred = CredW'(max_out_credits_p);

  brg_cgra_state_e         state_q, state_d;
  brg_cgra_req_t           hold_q, hold_d;
  brg_cgra_resp_t          ret_s;
  logic [IdxW-1:0]         rr_q, rr_d, owner_q, owner_d;
  logic [CredW-1:0]        credits_q, credits_d;
  logic [num_ports_p-1:0]  resp_v_q, resp_v_d;
  logic [data_width_p-1:0] resp_data_q, resp_data_d;
  logic                    err_q, err_d;

  logic [num_ports_p-1:0]  grant;
  logic [IdxW-1:0]         pick_idx;
  logic                    pick_v, pick, ret_id_ok, ret_inc;

  brg_cgra_rr_picker #(.num_ports_p(num_ports_p)) u_picker (
    .req_i   (bus.req_v),
    .ptr_i   (rr_q),
    .grant_o (grant),
    .idx_o   (pick_idx),
    .v_o     (pick_v)
  );

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    rr_d        = rr_q;
    owner_d     = owner_q;
    resp_v_d    = '0;
    resp_data_d = resp_data_q;
    ret_s       = '{load: bus.ret_load, reg_id: RegIdWidth'(bus.ret_reg_id), data: DataWidth'(bus.ret_data)};
    ret_id_ok   = int'(ret_s.reg_id) < num_ports_p;

    // The holding register frees up this cycle if idle or being drained by the CDC.
    pick = !reset_i && pick_v && (credits_q != '0) && ((state_q == IDLE) || bus.pkt_ready);

    if (state_q == LOCKED && bus.pkt_ready) state_d = IDLE;
    if (pick) begin
      state_d      = LOCKED;
      rr_d         = pick_idx;
      owner_d      = pick_idx;
      hold_d.store = bus.req_store[pick_idx];
      hold_d.addr  = AddrWidth'(bus.req_addr[int'(pick_idx)*addr_width_p +: addr_width_p]);
      hold_d.data  = DataWidth'(bus.req_data[int'(pick_idx)*data_width_p +: data_width_p]);
    end

    // A return with nothing outstanding is a protocol error and never over-fills the counter.
    ret_inc   = bus.ret_v && (credits_q != MaxCred);
    credits_d = credits_q - CredW'(pick) + CredW'(ret_inc);
    err_d     = err_q | (bus.ret_v && (!ret_id_ok || (credits_q == MaxCred)));

    if (bus.ret_v) begin
      resp_data_d = ret_s.load ? data_width_p'(ret_s.data) : '0;
      if (ret_id_ok) resp_v_d[ret_s.reg_id[IdxW-1:0]] = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      rr_q        <= IdxW'(num_ports_p - 1);
      owner_q     <= '0;
      credits_q   <= MaxCred;
      resp_v_q    <= '0;
      resp_data_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      rr_q        <= rr_d;
      owner_q     <= owner_d;
      credits_q   <= credits_d;
      resp_v_q    <= resp_v_d;
      resp_data_q <= resp_data_d;
      err_q       <= err_d;
    end
  end

  assign bus.req_ready  = pick ? grant : '0;
  assign bus.pkt_v      = (state_q == LOCKED);
  assign bus.pkt_store  = hold_q.store;
  assign bus.pkt_addr   = addr_width_p'(hold_q.addr);
  assign bus.pkt_data   = data_width_p'(hold_q.data);
  assign bus.pkt_reg_id = reg_id_width_p'(owner_q);
  assign bus.resp_v     = resp_v_q;
  assign bus.resp_data  = resp_data_q;
  assign out_credits_o  = credits_q;
  assign idle_o         = (credits_q == MaxCred) && (state_q == IDLE);
  assign err_o          = err_q;

endmodule

// File: tb/tb_brg_cgra_req_credit_arbiter.sv
// tb/tb_brg_cgra_req_credit_arbiter.sv - scoreboard bench for the CGRA request/credit arbiter
module tb_brg_cgra_req_credit_arbiter;

  localparam int NP = 4;
  localparam int AW = 28;
  localparam int DW = 32;
  localparam int MC = 32;
  localparam int RW = 5;
  localparam int CW = 6;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [CW-1:0] out_credits;
  logic          idle, err;

  brg_cgra_req_credit_arbiter_if #(.num_ports_p(NP), .addr_width_p(AW), .data_width_p(DW),
                                   .reg_id_width_p(RW)) bus ();

  brg_cgra_req_credit_arbiter #(
    .num_ports_p(NP), .addr_width_p(AW), .data_width_p(DW),
    .max_out_credits_p(MC), .reg_id_width_p(RW)
  ) dut (
    .clk_i         (clk),
    .reset_i       (reset),
    .bus           (bus),
    .out_credits_o (out_credits),
    .idle_o        (idle),
    .err_o         (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          store;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [RW-1:0] reg_id;
  } pkt_t;

  typedef struct packed {
    logic [NP-1:0] v;
    logic [DW-1:0] data;
  } rsp_t;

  pkt_t pkt_q[$];
  rsp_t rsp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_port(input int p, input logic st, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req_store[p]         = st;
    bus.req_addr[p*AW +: AW] = a;
    bus.req_data[p*DW +: DW] = d;
  endtask

  task automatic exp_pkt(input int p, input logic st, input logic [AW-1:0] a, input logic [DW-1:0] d);
    pkt_q.push_back('{store: st, addr: a, data: d, reg_id: RW'(p)});
  endtask

  task automatic do_ret(input int id, input logic ld, input logic [DW-1:0] d);
    bus.ret_v      = 1'b1;
    bus.ret_load   = ld;
    bus.ret_reg_id = RW'(id);
    bus.ret_data   = d;
    if (id < NP) rsp_q.push_back('{v: NP'(1 << id), data: (ld ? d : '0)});
  endtask

  // Packet monitor: pop on every forward handshake
  initial begin
    pkt_t e;
    forever begin
      @(negedge clk);
      #4;
      if (!reset && bus.pkt_v && bus.pkt_ready) begin
        chk("pkt_expected", 64'(pkt_q.size() != 0), 64'(1));
        if (pkt_q.size() != 0) begin
          e = pkt_q.pop_front();
          chk("pkt_store", 64'(bus.pkt_store), 64'(e.store));
          chk("pkt_addr", 64'(bus.pkt_addr), 64'(e.addr));
          chk("pkt_data", 64'(bus.pkt_data), 64'(e.data));
          chk("pkt_reg_id", 64'(bus.pkt_reg_id), 64'(e.reg_id));
        end
      end
    end
  end

  // Response monitor: pop on every response strobe
  initial begin
    rsp_t r;
    forever begin
      @(negedge clk);
      #4;
      if (bus.resp_v != '0) begin
        chk("rsp_expected", 64'(rsp_q.size() != 0), 64'(1));
        if (rsp_q.size() != 0) begin
          r = rsp_q.pop_front();
          chk("resp_v", 64'(bus.resp_v), 64'(r.v));
          chk("resp_data", 64'(bus.resp_data), 64'(r.data));
        end
      end
    end
  end

  initial begin
    bus.req_v      = '0;
    bus.req_store  = '0;
    bus.req_addr   = '0;
    bus.req_data   = '0;
    bus.pkt_ready  = 1'b0;
    bus.ret_v      = 1'b0;
    bus.ret_load   = 1'b0;
    bus.ret_reg_id = '0;
    bus.ret_data   = '0;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_pkt_v", 64'(bus.pkt_v), 64'(0));
    chk("rst_req_ready", 64'(bus.req_ready), 64'(0));
    chk("rst_resp_v", 64'(bus.resp_v), 64'(0));
    chk("rst_resp_data", 64'(bus.resp_data), 64'(0));
    chk("rst_err", 64'(err), 64'(0));
    chk("rst_idle", 64'(idle), 64'(1));
    chk("rst_credits", 64'(out_credits), 64'(MC));

    // Round robin over all ports at full throughput
    bus.pkt_ready = 1'b1;
    for (int p = 0; p < NP; p++) set_port(p, p[0], AW'(28'h1000000 + p), 32'hC0DE0000 + p);
    for (int k = 0; k < 8; k++) exp_pkt(k % NP, k[0], AW'(28'h1000000 + (k % NP)), 32'hC0DE0000 + (k % NP));
    bus.req_v = '1;
    repeat (8) @(negedge clk);
    bus.req_v = '0;
    repeat (3) @(negedge clk);
    chk("rr_credits", 64'(out_credits), 64'(MC - 8));
    chk("rr_pkt_v_drained", 64'(bus.pkt_v), 64'(0));
    for (int i = 0; i < 8; i++) begin
      do_ret(i % NP, 1'b1, 32'h5000 + i);
      @(negedge clk);
    end
    bus.ret_v = 1'b0;
    repeat (2) @(negedge clk);
    chk("rr_ret_credits", 64'(out_credits), 64'(MC));
    chk("rr_ret_idle", 64'(idle), 64'(1));

    // Credit exhaustion with a single busy port
    set_port(1, 1'b1, 28'h0111111, 32'h11110000);
    for (int k = 0; k < MC; k++) exp_pkt(1, 1'b1, 28'h0111111, 32'h11110000);
    bus.req_v = 4'b0010;
    repeat (40) @(negedge clk);
    chk("cr_credits_zero", 64'(out_credits), 64'(0));
    chk("cr_pkt_v", 64'(bus.pkt_v), 64'(0));
    chk("cr_ready_blocked", 64'(bus.req_ready), 64'(0));
    do_ret(1, 1'b0, 32'hFFFFFFFF);
    exp_pkt(1, 1'b1, 28'h0111111, 32'h11110000);
    @(negedge clk);
    bus.ret_v = 1'b0;
    #1;
    chk("cr_credits_one", 64'(out_credits), 64'(1));
    chk("cr_ready_regrant", 64'(bus.req_ready), 64'(4'b0010));
    repeat (4) @(negedge clk);
    chk("cr_credits_again_zero", 64'(out_credits), 64'(0));
    bus.req_v = '0;
    for (int i = 0; i < MC; i++) begin
      do_ret(i % NP, 1'b0, 32'h0BAD0000 + i);
      @(negedge clk);
    end
    bus.ret_v = 1'b0;
    repeat (2) @(negedge clk);
    chk("cr_restore", 64'(out_credits), 64'(MC));

    // Locked packet stays stable while the CDC stalls
    bus.pkt_ready = 1'b0;
    set_port(2, 1'b0, 28'h0222222, 32'h22222222);
    exp_pkt(2, 1'b0, 28'h0222222, 32'h22222222);
    bus.req_v = 4'b0100;
    @(negedge clk);
    bus.req_v = 4'b0001;
    for (int k = 0; k < 5; k++) begin
      set_port(0, k[0], AW'(28'h0A00000 + k), 32'hA0000000 + k);
      #1;
      chk("stall_pkt_v", 64'(bus.pkt_v), 64'(1));
      chk("stall_pkt_addr", 64'(bus.pkt_addr), 64'(28'h0222222));
      chk("stall_pkt_data", 64'(bus.pkt_data), 64'(32'h22222222));
      chk("stall_ready", 64'(bus.req_ready), 64'(0));
      @(negedge clk);
    end
    set_port(0, 1'b1, 28'h0A0000F, 32'hA000000F);
    exp_pkt(0, 1'b1, 28'h0A0000F, 32'hA000000F);
    bus.pkt_ready = 1'b1;
    #1;
    chk("b2b_ready", 64'(bus.req_ready), 64'(4'b0001));
    @(negedge clk);
    bus.req_v = '0;
    repeat (2) @(negedge clk);
    chk("stall_credits", 64'(out_credits), 64'(MC - 2));

    // Load return steered to port 3
    do_ret(3, 1'b1, 32'hDEADBEEF);
    @(negedge clk);
    bus.ret_v = 1'b0;
    chk("ret3_resp_v", 64'(bus.resp_v), 64'(4'b1000));
    chk("ret3_resp_data", 64'(bus.resp_data), 64'(32'hDEADBEEF));
    chk("ret3_credits", 64'(out_credits), 64'(MC - 1));
    do_ret(0, 1'b0, 32'h0);
    @(negedge clk);
    bus.ret_v = 1'b0;
    chk("ret0_credits", 64'(out_credits), 64'(MC));

    // Same-cycle issue and return at credits=5
    set_port(0, 1'b0, 28'h0300000, 32'h30000000);
    for (int k = 0; k < MC - 5; k++) exp_pkt(0, 1'b0, 28'h0300000, 32'h30000000);
    bus.req_v = 4'b0001;
    repeat (MC - 5) @(negedge clk);
    bus.req_v = '0;
    @(negedge clk);
    chk("same_pre_credits", 64'(out_credits), 64'(5));
    bus.req_v = 4'b0001;
    exp_pkt(0, 1'b0, 28'h0300000, 32'h30000000);
    do_ret(0, 1'b0, 32'h0);
    @(negedge clk);
    bus.req_v = '0;
    bus.ret_v = 1'b0;
    chk("same_credits", 64'(out_credits), 64'(5));
    @(negedge clk);
    for (int i = 0; i < MC - 5; i++) begin
      do_ret(i % NP, 1'b0, 32'h0);
      @(negedge clk);
    end
    bus.ret_v = 1'b0;
    @(negedge clk);
    chk("same_restore", 64'(out_credits), 64'(MC));
    chk("same_no_err", 64'(err), 64'(0));

    // Return with nothing outstanding
    do_ret(2, 1'b1, 32'h77);
    @(negedge clk);
    bus.ret_v = 1'b0;
    chk("over_err", 64'(err), 64'(1));
    chk("over_credits", 64'(out_credits), 64'(MC));
    chk("over_idle", 64'(idle), 64'(1));

    // Reset while locked with three outstanding
    set_port(0, 1'b1, 28'h0600000, 32'h60000000);
    exp_pkt(0, 1'b1, 28'h0600000, 32'h60000000);
    exp_pkt(0, 1'b1, 28'h0600000, 32'h60000000);
    bus.req_v = 4'b0001;
    repeat (3) @(negedge clk);
    bus.req_v     = '0;
    bus.pkt_ready = 1'b0;
    chk("lock_pkt_v", 64'(bus.pkt_v), 64'(1));
    chk("lock_credits", 64'(out_credits), 64'(MC - 3));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_pkt_v", 64'(bus.pkt_v), 64'(0));
    chk("mid_rst_credits", 64'(out_credits), 64'(MC));
    chk("mid_rst_idle", 64'(idle), 64'(1));
    chk("mid_rst_err", 64'(err), 64'(0));

    // Out-of-range reg_id still returns its credit
    bus.pkt_ready = 1'b1;
    exp_pkt(1, 1'b1, 28'h0111111, 32'h11110000);
    bus.req_v = 4'b0010;
    @(negedge clk);
    bus.req_v = '0;
    @(negedge clk);
    chk("badid_pre_credits", 64'(out_credits), 64'(MC - 1));
    do_ret(7, 1'b1, 32'h99);
    @(negedge clk);
    bus.ret_v = 1'b0;
    chk("badid_resp_v", 64'(bus.resp_v), 64'(0));
    chk("badid_credits", 64'(out_credits), 64'(MC));
    chk("badid_err", 64'(err), 64'(1));

    repeat (3) @(negedge clk);
    chk("pkt_q_empty", 64'(pkt_q.size()), 64'(0));
    chk("rsp_q_empty", 64'(rsp_q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
